// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: gathers PACK_NUM entries into one
// wide word and presents it on a valid/ready stream; flush emits a partial word.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4,
    parameter int LSB_FIRST  = 1,
    localparam int OUT_WIDTH = DATA_WIDTH * PACK_NUM,
    localparam int CNT_W     = $clog2(PACK_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]      out_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_FILL,
        S_HOLD,
        S_FLUSH
    } state_e;

    state_e                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
    logic                   pend_q, pend_d;
    logic                   flush_req_q, flush_req_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [CNT_W:0]         fill_lvl;
    logic [CNT_W-1:0]       lane;

    // Entries already captured plus the one still in flight.
    assign fill_lvl = {1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, pend_q};

    assign fifo_rd_en = !rst && (state_q == S_FILL) && !fifo_empty
                        && !flush_req_q
                        && (fill_lvl < (CNT_W+1)'(PACK_NUM));

    assign lane = (LSB_FIRST != 0) ? acc_cnt_q
                                   : CNT_W'(PACK_NUM - 1) - acc_cnt_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        pend_d      = fifo_rd_en;
        flush_req_d = flush_req_q | flush;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_FILL: begin
                if (pend_q) begin
                    for (int i = 0; i < PACK_NUM; i++) begin
                        if (lane == CNT_W'(i)) begin
                            acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
                        end
                    end
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == CNT_W'(PACK_NUM - 1)) begin
                        state_d = S_HOLD;
                    end
                end else if (flush_req_q) begin
                    if (acc_cnt_q != '0) begin
                        state_d = S_FLUSH;
                    end else begin
                        // Nothing buffered: drop the request.
                        flush_req_d = flush;
                    end
                end
            end
            S_HOLD, S_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    out_data_d  = acc_q;
                    out_cnt_d   = acc_cnt_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    acc_cnt_d   = '0;
                    flush_req_d = flush;
                    state_d     = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign busy      = (acc_cnt_q != '0) || pend_q || out_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO models with 1-cycle read latency and a
// word-level scoreboard built from the pushed byte stream.
module tb_fifo_rd_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic        gate_a;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        busy;

    logic        b_gate;
    logic        b_empty;
    logic        b_rd_en;
    logic [7:0]  b_dout;
    logic        b_valid;
    logic [31:0] b_data;
    logic [2:0]  b_cnt;
    logic        b_busy;
    logic        b_flush = 1'b0;
    logic        b_ready = 1'b1;

    logic [7:0]  mem   [0:1023];
    logic [7:0]  b_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          b_wr = 0;
    int          b_rd = 0;

    int          vectors = 0;
    int          errs = 0;
    int          words = 0;
    int          b_words = 0;
    logic [31:0] exp_data [$];
    int          exp_cnt  [$];
    logic [31:0] b_exp    [$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data;
    logic [2:0]  prev_cnt;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr) || gate_a;
    assign b_empty    = (b_wr == b_rd) || b_gate;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .LSB_FIRST(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .busy       (busy)
    );

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .LSB_FIRST(0)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (b_empty),
        .fifo_rd_en (b_rd_en),
        .fifo_dout  (b_dout),
        .flush      (b_flush),
        .out_valid  (b_valid),
        .out_ready  (b_ready),
        .out_data   (b_data),
        .out_cnt    (b_cnt),
        .busy       (b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO read ports: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
        if (b_rd_en) begin
            b_dout <= b_mem[b_rd % 16];
            b_rd   <= b_rd + 1;
        end
        b_gate <= rst ? 1'b0 : ~b_gate;
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            check("rd_while_empty", fifo_rd_en & fifo_empty, 0);
            check("b_rd_while_empty", b_rd_en & b_empty, 0);
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_cnt", out_cnt, prev_cnt);
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    check("spurious_word", out_data, 32'hxxxx_xxxx);
                end else begin
                    check("word_data", out_data, exp_data.pop_front());
                    check("word_cnt", out_cnt, exp_cnt.pop_front());
                end
                words++;
            end
            if (b_valid) begin
                if (b_exp.size() == 0) begin
                    check("b_spurious", b_data, 32'hxxxx_xxxx);
                end else begin
                    check("b_data", b_data, b_exp.pop_front());
                    check("b_cnt", b_cnt, 4);
                end
                b_words++;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_cnt  = out_cnt;
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 1024] = v;
        wr_ptr++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int c = 0;
        while (words < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("word_timeout", words >= n, 1);
    endtask

    function automatic logic [31:0] lsb_word(input logic [7:0] b0,
        input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        logic [7:0] rb [$];
        logic [7:0] v;
        int w0;
        int c;

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        gate_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_cnt", out_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_b_valid", b_valid, 0);
        step();
        rst = 1'b0;

        // Stream of 16 entries
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int i = 0; i < 16; i += 4) begin
            exp_data.push_back(lsb_word(8'(i), 8'(i+1), 8'(i+2), 8'(i+3)));
            exp_cnt.push_back(4);
        end
        wait_words(4, 200);
        repeat (4) step();
        @(negedge clk);
        check("stream_idle_rd", fifo_rd_en, 0);
        check("stream_idle_busy", busy, 0);

        // Backpressure
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        exp_data.push_back(32'h0302_0100);
        exp_data.push_back(32'h0706_0504);
        exp_cnt.push_back(4);
        exp_cnt.push_back(4);
        w0 = words;
        repeat (30) step();
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 32'h0302_0100);
        check("bp_rd_en", fifo_rd_en, 0);
        check("bp_busy", busy, 1);
        check("bp_fifo_left", wr_ptr - rd_ptr, 0);
        step();
        out_ready = 1'b1;
        wait_words(w0 + 2, 100);

        // Flush of a partial word, then flush with nothing buffered
        step();
        push(8'hA0);
        push(8'hA1);
        exp_data.push_back(32'h0000_A1A0);
        exp_cnt.push_back(2);
        repeat (6) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_words(w0 + 3, 50);
        repeat (3) step();
        w0 = words;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("flush_empty_words", words, w0);
        check("flush_empty_busy", busy, 0);

        // Flush racing the read strobe of the third entry
        step();
        push(8'hA0);
        push(8'hA1);
        repeat (6) step();
        push(8'hA2);
        flush = 1'b1;
        exp_data.push_back(32'h00A2_A1A0);
        exp_cnt.push_back(3);
        @(negedge clk);
        check("race_rd_en", fifo_rd_en, 1);
        step();
        flush = 1'b0;
        wait_words(w0 + 1, 50);

        // Bursty empty on the MSB-first instance
        for (int i = 0; i < 4; i++) begin
            b_mem[b_wr % 16] = 8'(8'h11 + i);
            b_wr++;
        end
        b_exp.push_back(32'h1112_1314);
        c = 0;
        while (b_words < 1 && c < 100) begin
            @(posedge clk);
            c++;
        end
        check("b_timeout", b_words, 1);

        // Reset mid-word, with an entry waiting during the reset cycle
        repeat (4) step();
        push(8'h55);
        push(8'h66);
        repeat (6) step();
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_valid", out_valid, 0);
        step();
        rst = 1'b1;
        push(8'h20);
        @(negedge clk);
        check("rst_cycle_rd_en", fifo_rd_en, 0);
        step();
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_cnt", out_cnt, 0);
        check("mid_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        push(8'h21);
        push(8'h22);
        push(8'h23);
        exp_data.push_back(32'h2322_2120);
        exp_cnt.push_back(4);
        w0 = words;
        wait_words(w0 + 1, 50);

        // Random traffic: bursty FIFO, random backpressure
        w0 = words;
        c = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            gate_a = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                v = 8'($urandom);
                push(v);
                rb.push_back(v);
            end
            if (rb.size() == 4) begin
                exp_data.push_back(lsb_word(rb[0], rb[1], rb[2], rb[3]));
                exp_cnt.push_back(4);
                rb.delete();
                c++;
            end
        end
        while (rb.size() != 0) begin
            v = 8'($urandom);
            push(v);
            rb.push_back(v);
            if (rb.size() == 4) begin
                exp_data.push_back(lsb_word(rb[0], rb[1], rb[2], rb[3]));
                exp_cnt.push_back(4);
                rb.delete();
                c++;
            end
        end
        step();
        gate_a = 1'b0;
        out_ready = 1'b1;
        wait_words(w0 + c, 2000);
        repeat (4) step();
        check("final_exp_left", exp_data.size(), 0);
        check("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
